frame_packer: RTL and testbench

- Downstream stage of the scaler→quantizer→rescaler chain; consumes the registered outData/outValid stream that chain produces.
- Packs the samples into an AXI-Stream with backpressure. Each 10 ms frame (delimited by syncTo10ms) becomes one packet, with tuser on the first sample and tlast on the last.
- Buffers samples in a small FIFO because the upstream chain cannot be stalled. Counts and flags any loss.

---
 rtl/frame_packer.sv | 113 +++++++++++
 tb/tb_frame_packer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/frame_packer.sv
// frame_packer: packs the pipeline sample stream into AXI-Stream packets, one per 10 ms frame,
// through a stage register and a FIFO that absorbs backpressure and counts any lost samples.
module frame_packer #(
   parameter int DATA_WIDTH    = 32,
   parameter int FIFO_DEPTH    = 16,
   parameter int MAX_FRAME_LEN = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sync_10ms,
   input  logic                          in_valid,
   input  logic [DATA_WIDTH-1:0]         in_data,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic [DATA_WIDTH-1:0]         m_tdata,
   output logic                          m_tlast,
   output logic                          m_tuser,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   drop_count,
   output logic                          overflow,
   output logic                          frame_err,
   input  logic                          clr_status
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(MAX_FRAME_LEN + 1);
   localparam int EW = DATA_WIDTH + 2;

   logic                  stg_vld_q, stg_first_q, stg_last_q, first_pend_q;
   logic [DATA_WIDTH-1:0] stg_data_q;
   logic [CW-1:0]         cnt_q;
   logic [EW-1:0]         mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [AW:0]           lvl_q;
   logic [15:0]           drop_q;
   logic                  ovf_q, ferr_q;

   logic                  forced, restart, push, full, pop, wr, drop;
   logic [CW-1:0]         cnt_d;
   logic [EW-1:0]         push_entry, head;

   always_comb begin
      forced     = stg_vld_q & stg_last_q;
      restart    = sync_10ms | forced;
      push       = stg_vld_q & (stg_last_q | sync_10ms | in_valid);
      push_entry = {stg_last_q | sync_10ms, stg_first_q, stg_data_q};
      cnt_d      = (restart ? '0 : cnt_q) + CW'(1);
      full       = lvl_q == (AW+1)'(FIFO_DEPTH);
      pop        = m_tvalid & m_tready;
      // a full FIFO still accepts a write when the head leaves in the same cycle
      wr         = push & (~full | pop);
      drop       = push & full & ~pop;
      head       = mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stg_vld_q    <= 1'b0;
         stg_first_q  <= 1'b0;
         stg_last_q   <= 1'b0;
         stg_data_q   <= '0;
         first_pend_q <= 1'b1;
         cnt_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         lvl_q        <= '0;
         drop_q       <= '0;
         ovf_q        <= 1'b0;
         ferr_q       <= 1'b0;
      end else begin
         if (in_valid) begin
            stg_vld_q    <= 1'b1;
            stg_data_q   <= in_data;
            stg_first_q  <= first_pend_q | restart;
            stg_last_q   <= cnt_d == CW'(MAX_FRAME_LEN);
            cnt_q        <= cnt_d;
            first_pend_q <= 1'b0;
         end else begin
            if (push) stg_vld_q <= 1'b0;
            if (restart) begin
               first_pend_q <= 1'b1;
               cnt_q        <= '0;
            end
         end
         if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         lvl_q <= lvl_q + (AW+1)'(wr) - (AW+1)'(pop);
         if (drop) begin
            drop_q <= clr_status ? 16'd1 : (drop_q == 16'hFFFF ? drop_q : drop_q + 16'd1);
            ovf_q  <= 1'b1;
            ferr_q <= (ferr_q & ~clr_status) | push_entry[EW-1];
         end else if (clr_status) begin
            drop_q <= '0;
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem_q[wr_ptr_q] <= push_entry;
   end

   always_comb begin
      m_tvalid   = lvl_q != '0;
      m_tdata    = m_tvalid ? head[DATA_WIDTH-1:0] : '0;
      m_tuser    = m_tvalid & head[DATA_WIDTH];
      m_tlast    = m_tvalid & head[DATA_WIDTH+1];
      fifo_level = lvl_q;
      drop_count = drop_q;
      overflow   = ovf_q;
      frame_err  = ferr_q;
   end
endmodule

// File: tb/tb_frame_packer.sv
// tb_frame_packer: scoreboard bench; a frame-level model predicts every beat and status value,
// and a negedge monitor compares them against the AXI-Stream side.
module tb_frame_packer;
   localparam int DEPTH = 16;
   localparam int MAXL  = 8;

   logic        clk = 0, rst = 1, sync_10ms = 0, in_valid = 0, m_tready = 0, clr_status = 0;
   logic [31:0] in_data = 0;
   logic        m_tvalid, m_tlast, m_tuser, overflow, frame_err;
   logic [31:0] m_tdata;
   logic [4:0]  fifo_level;
   logic [15:0] drop_count;

   frame_packer #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .MAX_FRAME_LEN(MAXL)) dut (
      .clk(clk), .rst(rst), .sync_10ms(sync_10ms), .in_valid(in_valid), .in_data(in_data),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
      .m_tuser(m_tuser), .fifo_level(fifo_level), .drop_count(drop_count),
      .overflow(overflow), .frame_err(frame_err), .clr_status(clr_status));

   always #5 clk = ~clk;

   typedef struct {logic [31:0] d; logic f; logic l;} beat_t;
   beat_t q[$];
   int    n_tests = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: samples wait in a one-deep holding slot until their frame position is known
   logic        held = 0, first_pend = 1, popped = 0;
   beat_t       h, e;
   int          cnt = 0, occ;
   logic        pop, forced, restart, do_push;
   logic [15:0] e_drop = 0;
   logic        e_ovf = 0, e_ferr = 0;

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         popped = 0; held = 0; first_pend = 1; cnt = 0;
         e_drop = 0; e_ovf = 0; e_ferr = 0;
      end else begin
         occ = q.size() + int'(popped);
         pop = popped;
         popped = 0;
         forced  = held && h.l;
         restart = sync_10ms || forced;
         do_push = held && (h.l || sync_10ms || in_valid);
         e = h;
         e.l = h.l || sync_10ms;
         if (do_push) held = 0;
         if (in_valid) begin
            cnt = (restart ? 0 : cnt) + 1;
            held = 1;
            h.d = in_data;
            h.f = first_pend || restart;
            h.l = (cnt == MAXL);
            first_pend = 0;
         end else if (restart) begin
            first_pend = 1;
            cnt = 0;
         end
         if (do_push && occ == DEPTH && !pop) begin
            e_drop = clr_status ? 16'd1 : (e_drop == 16'hFFFF ? e_drop : e_drop + 16'd1);
            e_ovf  = 1;
            e_ferr = (e_ferr && !clr_status) || e.l;
         end else begin
            if (do_push) q.push_back(e);
            if (clr_status) begin
               e_drop = 0; e_ovf = 0; e_ferr = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("level", 32'(fifo_level), 32'(q.size()));
      chk("tvalid", 32'(m_tvalid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("tdata", m_tdata, q[0].d);
         chk("tuser", 32'(m_tuser), 32'(q[0].f));
         chk("tlast", 32'(m_tlast), 32'(q[0].l));
         if (m_tready) begin
            void'(q.pop_front());
            popped = 1;
         end
      end
      chk("drop_count", 32'(drop_count), 32'(e_drop));
      chk("overflow", 32'(overflow), 32'(e_ovf));
      chk("frame_err", 32'(frame_err), 32'(e_ferr));
   end

   task automatic cyc(input logic v, input logic [31:0] d, input logic s, input logic rdy,
                      input logic c = 0, input logic r = 0);
      in_valid = v; in_data = d; sync_10ms = s; m_tready = rdy; clr_status = c; rst = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) cyc(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) cyc(1, 32'h10 + i, 0, 1);
      cyc(0, 0, 1, 1);
      repeat (4) cyc(0, 0, 0, 1);
      cyc(1, 32'h1F, 0, 1);
      cyc(1, 32'h20, 1, 1);
      cyc(0, 0, 1, 1);
      repeat (4) cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) cyc(1, 32'h100 + i, 0, 0);
      cyc(0, 0, 0, 0);
      chk("t3_level", 32'(fifo_level), 32'd16);
      chk("t3_drop", 32'(drop_count), 32'd3);
      chk("t3_overflow", 32'(overflow), 32'd1);
      repeat (20) cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 1, 1);
      cyc(0, 0, 1, 1);
      cyc(1, 32'h55, 0, 1);
      cyc(0, 0, 1, 1);
      repeat (4) cyc(0, 0, 0, 1);
      for (int i = 0; i < 7; i++) cyc(1, 32'h200 + i, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      chk("t6_tvalid", 32'(m_tvalid), 32'd0);
      chk("t6_level", 32'(fifo_level), 32'd0);
      cyc(1, 32'h300, 0, 1);
      cyc(0, 0, 1, 1);
      repeat (3) cyc(0, 0, 0, 1);
      for (int i = 0; i < 3000; i++) begin
         logic rdy;
         rdy = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
         cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 19) == 0, rdy,
             $urandom_range(0, 63) == 0, $urandom_range(0, 499) == 0);
      end
      cyc(0, 0, 1, 1);
      repeat (40) cyc(0, 0, 0, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
